// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, op encoding, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // multordivE encoding
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: dout = neg ? ~din + cin : din.
// Latency: combinational.
// Backpressure: none.
// Holding cin at 1 gives a plain negate. Driving cin with "lower word is zero"
// lets two instances negate a double-width value as a chained pair.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic             cin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = (neg ? ~din : din) + {{(WIDTH-1){1'b0}}, neg & cin};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide writing architectural HI/LO.
// Latency: WIDTH+1 cycles from the start edge to the HI/LO update (done pulses the cycle after).
// Backpressure: busy/stallMD hold off HI/LO readers and writers; startE while busy is dropped.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             multordivE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hlreadD,
  input  logic             hlwriteD,
  output logic             busy,
  output logic             stallMD,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             op, op_n;
  logic             neg_q, neg_q_n;   // quotient / product sign
  logic             neg_r, neg_r_n;   // remainder sign (dividend sign)
  logic             div0, div0_n;
  logic [WIDTH-1:0] opa, opa_n, opb, opb_n;
  logic [WIDTH-1:0] acc_hi, acc_hi_n, acc_lo, acc_lo_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             busy_n, done_n;

  logic [WIDTH-1:0] a_mag, b_mag, hi_src, hi_fix, lo_fix;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok, is_div0;
  logic             start_while_busy;

  assign stallMD          = busy & (hlreadD | hlwriteD);
  assign start_while_busy = startE & busy;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg(srcaE[WIDTH-1]), .cin(1'b1), .din(srcaE), .dout(a_mag)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg(srcbE[WIDTH-1]), .cin(1'b1), .din(srcbE), .dout(b_mag)
  );

  // Result sign correction. For mult the pair negates the full 2*WIDTH product;
  // for div by zero the dividend magnitude is re-signed to give back srcaE.
  assign is_div0 = (op == OP_DIV) && div0;
  assign hi_src  = is_div0 ? opa : acc_hi;

  mdu_negate #(.WIDTH(WIDTH)) u_fix_hi (
    .neg ((op == OP_DIV) ? neg_r : neg_q),
    .cin ((op == OP_DIV) ? 1'b1 : (acc_lo == '0)),
    .din (hi_src),
    .dout(hi_fix)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_fix_lo (
    .neg(neg_q), .cin(1'b1), .din(acc_lo), .dout(lo_fix)
  );

  // Datapath step terms: shift-add for mult, restoring trial subtract for div.
  // div_diff may drop bit WIDTH because it is only used when the difference fits.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opb};
  assign div_diff  = div_shift[WIDTH-1:0] - opb;

  // Next-state logic for the FSM, iteration datapath and HI/LO.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    div0_n   = div0;
    opa_n    = opa;
    opb_n    = opb;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    hi_n     = hi;
    lo_n     = lo;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (startE) begin
          state_n  = RUN;
          busy_n   = 1'b1;
          cnt_n    = '0;
          op_n     = multordivE;
          opa_n    = a_mag;
          opb_n    = b_mag;
          neg_q_n  = srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
          neg_r_n  = srcaE[WIDTH-1];
          div0_n   = (srcbE == '0);
          acc_hi_n = '0;
          acc_lo_n = (multordivE == OP_DIV) ? a_mag : b_mag;
        end
      end
      RUN: begin
        cnt_n = cnt + CW'(1);
        if (op == OP_MULT) begin
          acc_hi_n = mul_sum[WIDTH:1];
          acc_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
          acc_hi_n = div_ok ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_n = {acc_lo[WIDTH-2:0], div_ok};
        end
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        hi_n    = hi_fix;
        lo_n    = is_div0 ? '1 : lo_fix;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // All state; reset abandons any operation without touching HI/LO beyond clearing them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= OP_MULT;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op     <= op_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      div0   <= div0_n;
      opa    <= opa_n;
      opb    <= opb_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      hi     <= hi_n;
      lo     <= lo_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // An upstream issue while busy is a hazard-unit bug; the request is dropped.
  assert property (@(posedge clk) disable iff (!reset) !start_while_busy)
    else $warning("muldiv_unit: startE while busy, request dropped");

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, stall and reset.
// Latency: each operation observed over WIDTH+1 cycles plus one for the done pulse.
// Backpressure: stallMD sampled every busy cycle with hlreadD held high.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         startE = 1'b0;
  logic         multordivE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         hlreadD = 1'b0;
  logic         hlwriteD = 1'b0;
  logic         busy, stallMD, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .startE    (startE),
    .multordivE(multordivE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .hlreadD   (hlreadD),
    .hlwriteD  (hlwriteD),
    .busy      (busy),
    .stallMD   (stallMD),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op for one edge (edge k); returns 1ns after edge k.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    startE     = 1'b1;
    multordivE = op;
    srcaE      = a;
    srcbE      = b;
    @(posedge clk);
    #1;
    startE = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    logic [W-1:0] hi0, lo0;
    int fin;
    hi0 = hi;
    lo0 = lo;
    fin = 0;
    issue(op, a, b);
    chk({tag, ".busy_rise"}, 64'(busy), 64'(1));
    for (int i = 1; i <= 40 && fin == 0; i++) begin
      @(posedge clk);
      #1;
      if (!busy) fin = i;
      else if (i == W) chk({tag, ".hold"}, {hi, lo}, {hi0, lo0});
    end
    chk({tag, ".latency"}, 64'(fin), 64'(W + 1));
    chk({tag, ".done"}, 64'(done), 64'(1));
    chk({tag, ".hi"}, 64'(hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(lo), 64'(elo));
    @(posedge clk);
    #1;
    chk({tag, ".done_fall"}, 64'(done), 64'(0));
    chk({tag, ".stable"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin, scnt;

    // Reset state; a stall request must not matter while idle.
    hlreadD  = 1'b1;
    hlwriteD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.hilo", {hi, lo}, 64'(0));
    chk("rst.stall", 64'(stallMD), 64'(0));
    @(negedge clk);
    reset    = 1'b1;
    hlreadD  = 1'b0;
    hlwriteD = 1'b0;

    do_op("mul_7_m3",   1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mul_mn_mn",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("mul_m6_m7",  1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_002A);
    do_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_100_7",  1'b1, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);
    do_op("div_5_0",    1'b1, 32'd5,        32'd0,        32'h0000_0005, 32'hFFFF_FFFF);
    do_op("div_m5_0",   1'b1, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
    do_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    chk("div_ovf.known", 64'($isunknown({hi, lo})), 64'(0));

    // Stall while busy, plus an illegal re-issue in the middle of RUN.
    @(negedge clk);
    hlreadD = 1'b1;
    #1;
    chk("stall.idle", 64'(stallMD), 64'(0));
    issue(1'b0, 32'd3, 32'd5);
    scnt = int'(stallMD);
    fin  = 0;
    for (int i = 1; i <= 40 && fin == 0; i++) begin
      @(negedge clk);
      if (i == 5) begin
        startE     = 1'b1;
        multordivE = 1'b1;
        srcaE      = 32'd99;
        srcbE      = 32'd1;
        #1;
        chk("viol.flag", 64'(dut.start_while_busy), 64'(1));
      end
      @(posedge clk);
      #1;
      startE = 1'b0;
      if (!busy) begin
        fin = i;
        chk("stall.after_fix", 64'(stallMD), 64'(0));
      end else begin
        scnt += int'(stallMD);
      end
    end
    chk("stall.latency", 64'(fin), 64'(W + 1));
    chk("stall.cycles", 64'(scnt), 64'(W + 1));
    chk("viol.hi", 64'(hi), 64'(0));
    chk("viol.lo", 64'(lo), 64'(15));
    @(negedge clk);
    hlreadD = 1'b0;

    // Asynchronous reset 10 cycles into a divide, checked before the next edge.
    issue(1'b1, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.done", 64'(done), 64'(0));
    chk("arst.hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("arst.no_partial", {hi, lo}, 64'(0));
    chk("arst.idle", 64'(busy), 64'(0));

    do_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 startE  input  1  E-stage multiply/divide issue (controller hlwriteE).
REQ-005 multordivE  input  1  operation select, 0 = signed mult, 1 = signed div.
REQ-006 srcaE  input  WIDTH  multiplicand / dividend (rs).
REQ-007 srcbE  input  WIDTH  multiplier / divisor (rt).
REQ-008 hlreadD  input  1  D-stage instruction reads HI or LO (mfhi/mflo).
REQ-009 hlwriteD  input  1  D-stage instruction is mult/div.
REQ-010 busy  output  1  operation in progress.
REQ-011 stallMD  output  1  stall request to the hazard unit.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 The FSM shall have three states: IDLE, RUN and FIX.
REQ-015 In IDLE, startE=1 at an edge shall latch operand magnitudes, result sign flags and op, clear the iteration counter, and enter RUN.
REQ-016 RUN shall perform one shift-add (mult) or one restoring-subtract (div) iteration per cycle, for exactly WIDTH cycles, then enter FIX.
REQ-017 FIX shall apply two's-complement sign correction, write hi/lo, pulse done for the following cycle, and return to IDLE.
REQ-018 Latency: with start at edge k, hi/lo shall change at edge k+WIDTH+1, and busy shall be high from edge k to edge k+WIDTH+1 (33 cycles at WIDTH=32).
REQ-019 Mult: {hi,lo} shall equal the signed 2*WIDTH-bit product.
REQ-020 Div: lo shall equal the quotient truncated toward zero, and hi shall equal the remainder, carrying the dividend's sign.
REQ-021 Divide by zero: lo shall be all ones and hi shall equal srcaE, regardless of sign.
REQ-022 Overflow case, most-negative / -1: lo shall be the most-negative value and hi shall be 0.
REQ-023 stallMD shall equal busy & (hlreadD | hlwriteD), combinationally.
REQ-024 startE while busy is a protocol violation; the block shall ignore it, and an assertion shall flag it.
REQ-025 hi/lo shall hold their value at all times except the FIX edge.
REQ-026 A flushed E stage delivers startE=0; the block has no flush input.

Reset
REQ-027 Asserting reset (low) shall asynchronously force state to IDLE, counter to 0, busy=0, done=0, hi=0 and lo=0.
REQ-028 Reset asserted mid-RUN or mid-FIX shall abandon the operation with no partial HI/LO update.
REQ-029 After reset deasserts, the first startE shall behave exactly as from power-up.

Structure
REQ-030 A shared package mdu_pkg shall hold the state enum (IDLE, RUN, FIX), the op encoding constants and the WIDTH default.
REQ-031 The counter width shall be derived as $clog2(WIDTH)+1.
REQ-032 One sub-module, mdu_negate (conditional two's-complement of a WIDTH-bit value), shall be used for the operand-magnitude and result-correction steps.
REQ-033 All state shall reside in a single always_ff with asynchronous active-low reset; the next-state logic shall be in always_comb.

Verification
REQ-034 mult 7 x 0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge k+33; busy high for exactly 33 cycles; done high for 1 cycle.
REQ-035 mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-036 div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005.
REQ-037 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, with no X values.
REQ-038 hlreadD=1 while busy -> stallMD=1 every cycle until the FIX edge, then 0; startE pulsed during RUN -> result unchanged and assertion fires.
REQ-039 reset driven low 10 cycles into a div -> busy, hi, lo and done go to 0 immediately, without waiting for clk; a new mult 3 x 4 -> lo=12, hi=0.
